// File: rtl/fwd_hazard_ctrl.sv
// Forwarding select and load-use/RAW hazard controller for a 5-stage MIPS pipeline.
// Optional macro FWD_EN enables operand forwarding; otherwise RAW hazards stall until WB.
module fwd_hazard_ctrl #(
  parameter int REG_AW     = 5,
  parameter int LOAD_STALL = 1,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              flush,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              idex_bubble,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic [1:0]        hz_state,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    RUN       = 2'b00,
    LU_STALL  = 2'b01,
    RAW_STALL = 2'b10
  } hz_state_t;

  hz_state_t state, state_nxt;

  // Stage records: _p0 = EX, _p1 = MEM, _p2 = WB
  logic              vld_p0, vld_p1, vld_p2;
  logic [REG_AW-1:0] dst_p0, dst_p1, dst_p2;
  logic              we_p0, we_p1, we_p2;
  logic              ld_p0, ld_p1, ld_p2;

  logic rs_ex_hit, rt_ex_hit, rs_mem_hit, rt_mem_hit;
  logic ex_hit, mem_hit;
  logic lu_hit, raw_hit;

  function automatic logic rec_match(
    input logic              v,
    input logic              we,
    input logic [REG_AW-1:0] dst,
    input logic [REG_AW-1:0] src,
    input logic              use_src
  );
    return v & we & use_src & (src != '0) & (dst == src);
  endfunction

  function automatic logic [1:0] fwd_pick(input logic ex_m, input logic mem_m);
    if (ex_m)
      return 2'b01;
    else if (mem_m)
      return 2'b10;
    else
      return 2'b00;
  endfunction

  assign rs_ex_hit  = rec_match(vld_p0, we_p0, dst_p0, id_rs, id_use_rs);
  assign rt_ex_hit  = rec_match(vld_p0, we_p0, dst_p0, id_rt, id_use_rt);
  assign rs_mem_hit = rec_match(vld_p1, we_p1, dst_p1, id_rs, id_use_rs);
  assign rt_mem_hit = rec_match(vld_p1, we_p1, dst_p1, id_rt, id_use_rt);
  assign ex_hit     = rs_ex_hit | rt_ex_hit;
  assign mem_hit    = rs_mem_hit | rt_mem_hit;

`ifdef FWD_EN
  // A slow data memory also makes a load sitting in MEM a load-use hazard.
  assign lu_hit  = id_valid & ((ex_hit & ld_p0) |
                               ((LOAD_STALL == 2) & mem_hit & ld_p1));
  assign raw_hit = 1'b0;
`else
  assign lu_hit  = 1'b0;
  assign raw_hit = id_valid & (ex_hit | mem_hit);
`endif

  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_bubble = 1'b0;
    state_nxt   = RUN;
    if (flush) begin
      idex_bubble = 1'b1;
    end else if (lu_hit) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
      state_nxt   = LU_STALL;
    end else if (raw_hit) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
      state_nxt   = RAW_STALL;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= RUN;
    else
      state <= state_nxt;
  end

  assign hz_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0 <= 1'b0;
      dst_p0 <= '0;
      we_p0  <= 1'b0;
      ld_p0  <= 1'b0;
      vld_p1 <= 1'b0;
      dst_p1 <= '0;
      we_p1  <= 1'b0;
      ld_p1  <= 1'b0;
      vld_p2 <= 1'b0;
      dst_p2 <= '0;
      we_p2  <= 1'b0;
      ld_p2  <= 1'b0;
    end else begin
      vld_p0 <= id_valid & ~idex_bubble;
      dst_p0 <= id_rd;
      we_p0  <= id_reg_write;
      ld_p0  <= id_mem_read;
      vld_p1 <= vld_p0;
      dst_p1 <= dst_p0;
      we_p1  <= we_p0;
      ld_p1  <= ld_p0;
      vld_p2 <= vld_p1;
      dst_p2 <= dst_p1;
      we_p2  <= we_p1;
      ld_p2  <= ld_p1;
    end
  end

  // WB record has no consumer here: the regfile is write-before-read.
  logic unused_rec;
  assign unused_rec = ^{vld_p2, dst_p2, we_p2, ld_p2, ld_p1, ld_p0};

`ifdef FWD_EN
  logic [1:0] sel_a_p0, sel_b_p0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_a_p0 <= 2'b00;
      sel_b_p0 <= 2'b00;
    end else if (idex_bubble || !id_valid) begin
      sel_a_p0 <= 2'b00;
      sel_b_p0 <= 2'b00;
    end else begin
      sel_a_p0 <= fwd_pick(rs_ex_hit, rs_mem_hit);
      sel_b_p0 <= fwd_pick(rt_ex_hit, rt_mem_hit);
    end
  end

  assign fwd_a_sel = sel_a_p0;
  assign fwd_b_sel = sel_b_p0;
`else
  assign fwd_a_sel = 2'b00;
  assign fwd_b_sel = 2'b00;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt <= '0;
    else if (!pc_write && (stall_cnt != '1))
      stall_cnt <= stall_cnt + CNT_W'(1);
  end

endmodule
